// File: rtl/slave_in_port_burst.sv
// Serial slave input port with burst expansion: deserialises an LSB-first header
// and write data, then emits one rx_done beat per burst word. Optional: BURST_BOUNDARY_EN.
module slave_in_port_burst #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int BURST_W = 13,
  parameter int BOUND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              master_valid,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              rx_address,
  input  logic              rx_data,
  input  logic              rx_burst,
  output logic              slave_ready,
  output logic              rx_done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              is_write
);

  localparam int HDR_LEN = (ADDR_W > BURST_W) ? ADDR_W : BURST_W;
  localparam int CNT_W   = $clog2(HDR_LEN + 1);

  localparam logic [CNT_W-1:0]   HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   ADDR_CNT  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]   BURST_CNT = CNT_W'(BURST_W);
  localparam logic [CNT_W-1:0]   DATA_CNT  = CNT_W'(DATA_W);
  localparam logic [BURST_W-1:0] ONE_BEAT  = BURST_W'(1);

  if (DATA_W > HDR_LEN) begin : g_bad_data_w
    $error("DATA_W must not exceed the header length");
  end
  if (BOUND_W >= ADDR_W) begin : g_bad_bound_w
    $error("BOUND_W must be smaller than ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, HDR, WBEAT, RBEAT} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_W-1:0]    addr_sr;
  logic [BURST_W-1:0]   burst_sr;
  logic [DATA_W-1:0]    data_sr;
  logic [BURST_W-1:0]   beats_left;
  logic                 wr_q;

  // Handshake: valid/ready with exactly one of read_en/write_en; one-cycle accept in IDLE.
  logic hs;
  assign slave_ready = (state == IDLE);
  assign hs          = master_valid & slave_ready & (read_en ^ write_en);

  logic [ADDR_W-1:0]  addr_shift;
  logic [BURST_W-1:0] burst_shift;
  logic [DATA_W-1:0]  data_shift;
  assign addr_shift  = {rx_address, addr_sr[ADDR_W-1:1]};
  assign burst_shift = {rx_burst, burst_sr[BURST_W-1:1]};
  assign data_shift  = {rx_data, data_sr[DATA_W-1:1]};

  // On the last header edge the final bit is still on the line, so fold it in here.
  logic [ADDR_W-1:0]  addr_fin;
  logic [BURST_W-1:0] burst_fin;
  logic [DATA_W-1:0]  data_fin;
  assign addr_fin  = (cnt < ADDR_CNT)  ? addr_shift  : addr_sr;
  assign burst_fin = (cnt < BURST_CNT) ? burst_shift : burst_sr;
  assign data_fin  = (cnt < DATA_CNT)  ? data_shift  : data_sr;

  logic [ADDR_W-1:0] addr_inc;
`ifdef BURST_BOUNDARY_EN
  assign addr_inc = {address[ADDR_W-1:BOUND_W], address[BOUND_W-1:0] + BOUND_W'(1)};
`else
  assign addr_inc = address + ADDR_W'(1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_sr    <= '0;
      burst_sr   <= '0;
      data_sr    <= '0;
      beats_left <= '0;
      wr_q       <= 1'b0;
      rx_done    <= 1'b0;
      address    <= '0;
      data       <= '0;
      is_write   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            addr_sr  <= addr_shift;
            burst_sr <= burst_shift;
            if (write_en) data_sr <= data_shift;
            wr_q  <= write_en;
            cnt   <= CNT_W'(1);
            state <= HDR;
          end
        end

        HDR: begin
          if (cnt < ADDR_CNT)          addr_sr  <= addr_shift;
          if (cnt < BURST_CNT)         burst_sr <= burst_shift;
          if (wr_q && cnt < DATA_CNT)  data_sr  <= data_shift;
          cnt <= cnt + CNT_W'(1);
          if (cnt == HDR_LAST) begin
            rx_done  <= 1'b1;
            address  <= addr_fin;
            is_write <= wr_q;
            if (wr_q) data <= data_fin;
            cnt <= '0;
            // A zero burst field is a single beat.
            if (burst_fin <= ONE_BEAT) begin
              state <= IDLE;
            end else begin
              beats_left <= burst_fin - ONE_BEAT;
              state      <= wr_q ? WBEAT : RBEAT;
            end
          end
        end

        WBEAT: begin
          data_sr <= data_shift;
          if (cnt == DATA_LAST) begin
            rx_done    <= 1'b1;
            data       <= data_shift;
            address    <= addr_inc;
            is_write   <= 1'b1;
            cnt        <= '0;
            beats_left <= beats_left - ONE_BEAT;
            if (beats_left == ONE_BEAT) state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RBEAT: begin
          rx_done    <= 1'b1;
          address    <= addr_inc;
          is_write   <= 1'b0;
          beats_left <= beats_left - ONE_BEAT;
          if (beats_left == ONE_BEAT) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/slave_in_port_burst.md
Name: slave_in_port_burst

Overview:
- Parametrised successor of the serial slave input port.
- Deserialises a transaction header (address plus burst length) and write data from LSB-first serial lines.
- Expands multi-beat bursts into per-beat parallel address/data words with incrementing address.
- Sits between the bus serial interconnect and a slave memory/register array. Presents one `rx_done` pulse per beat.

Parameters:
- ADDR_W, 12, address width in bits.
- DATA_W, 8, data width in bits. Must be <= HDR_LEN.
- BURST_W, 13, burst-length field width in bits.
- BOUND_W, 4, log2 of the burst wrap window. Used only with BURST_BOUNDARY_EN.
- Derived: HDR_LEN = max(ADDR_W, BURST_W), header length in cycles (13 at defaults).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- master_valid  in  1  master presents a transaction
- read_en  in  1  transaction is a read
- write_en  in  1  transaction is a write
- rx_address  in  1  serial address, LSB first
- rx_data  in  1  serial write data, LSB first
- rx_burst  in  1  serial burst length, LSB first
- slave_ready  out  1  high when the FSM is in IDLE
- rx_done  out  1  one-cycle pulse per completed beat
- address  out  ADDR_W  beat address; valid while rx_done is high, held otherwise
- data  out  DATA_W  beat write data; valid with rx_done on writes, held on reads
- is_write  out  1  beat direction; valid with rx_done

Behaviour:
- Reset (asynchronous): state = IDLE; all shift registers and counters = 0; rx_done = 0; address = 0; data = 0; is_write = 0; slave_ready = 1. Reset mid-transaction aborts it with no further rx_done.
- Handshake:
  - hs = master_valid & slave_ready & (read_en ^ write_en).
  - read_en and write_en both high: no handshake, stay in IDLE.
  - The hs cycle is cycle 0. Bit 0 of rx_address, rx_burst and rx_data is sampled on that edge.
- Header (HDR state):
  - Address bits are sampled cycles 0..ADDR_W-1, burst bits cycles 0..BURST_W-1, first-beat data bits cycles 0..DATA_W-1 (writes only).
  - Direction is latched at hs.
  - master_valid, read_en and write_en are ignored after hs.
- Burst length: N = burst field, with 0 treated as 1. Beat counter is BURST_W bits wide.
- Beat 1: rx_done is high in cycle HDR_LEN; address, data and is_write update on the same edge.
- Write burst (WBEAT state, N>1):
  - Beat k data is sampled over the DATA_W cycles following beat k-1's completion.
  - rx_done for beat k is in cycle HDR_LEN + (k-1)*DATA_W, with no gap cycles.
- Read burst (RBEAT state, N>1): rx_done for beat k is in cycle HDR_LEN + (k-1), i.e. consecutive cycles.
- Address increment: address_k = address_1 + (k-1), modulo 2^ADDR_W (wraps 0xFFF -> 0x000).
- Completion: the FSM returns to IDLE on the edge that asserts the final rx_done, so slave_ready = 1 in the cycle of the final pulse. A new hs may occur in that cycle.
- Outputs: address and data change only on edges that assert rx_done, and are otherwise stable.
- FSM transitions:
  - IDLE -> HDR on hs.
  - HDR -> IDLE when N = 1.
  - HDR -> WBEAT when N > 1 and write.
  - HDR -> RBEAT when N > 1 and read.
  - WBEAT/RBEAT -> IDLE after beat N.
  - Illegal state -> IDLE.

Optional Feature:
- Macro: BURST_BOUNDARY_EN.
- Defined: burst address increments only the low BOUND_W bits, modulo 2^BOUND_W. The upper ADDR_W-BOUND_W bits stay fixed at the beat-1 value (aligned wrapping burst).
- Undefined: full-width increment modulo 2^ADDR_W. BOUND_W is unused.

Test Plan:
- Single write, addr 0x0A5, data 0x3C, burst 0 -> one rx_done in cycle 13; address = 0x0A5, data = 0x3C, is_write = 1; slave_ready = 1 from cycle 13.
- Single read, addr 0xFFF, burst 1 -> one rx_done in cycle 13; address = 0xFFF, is_write = 0; data unchanged.
- Write burst 3, addr 0x0FE, data 0x11/0x22/0x33 -> rx_done in cycles 13, 21, 29; addresses 0x0FE, 0x0FF, 0x100; data 0x11, 0x22, 0x33.
- Read burst 4, addr 0xFFE -> rx_done in cycles 13-16; addresses 0xFFE, 0xFFF, 0x000, 0x001. With BURST_BOUNDARY_EN (BOUND_W = 4): 0xFFE, 0xFFF, 0xFF0, 0xFF1.
- Reset asserted in cycle 20 of the write-burst test -> no further rx_done; outputs = 0; slave_ready = 1. A following single write of 0x123/0x5A completes correctly.
- master_valid = 1 with read_en = write_en = 1 for 5 cycles -> no rx_done; slave_ready remains 1; state remains IDLE.
